arb_merge_rr_mmu: RTL and testbench



---
 rtl/arb_merge_rr_mmu.sv | 95 +++++++++
 tb/tb_arb_merge_rr_mmu.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_merge_rr_mmu.sv
// N-port arbitrating merge for the MMU request paths: one holding stage per port,
// round-robin or fixed-priority arbitration, grant held stable while the output stalls.
module arb_merge_rr_mmu #(
    parameter int unsigned NUM_PORTS  = 8,
    parameter int unsigned DATA_WIDTH = 79,
    parameter bit          RR_EN      = 1'b1,
    localparam int unsigned ID_W      = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NUM_PORTS-1:0]            i_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_data,
    output logic [NUM_PORTS-1:0]            o_ready,
    output logic                            o_valid,
    output logic [DATA_WIDTH-1:0]           o_data,
    output logic [ID_W-1:0]                 o_id,
    input  logic                            i_ready,
    output logic                            o_busy
);

    logic [NUM_PORTS-1:0]  full;
    logic [DATA_WIDTH-1:0] data_q [NUM_PORTS];
    logic [ID_W-1:0]       rr_ptr;
    logic                  lock_vld;
    logic [ID_W-1:0]       lock_id;

    logic [ID_W-1:0]       grant;
    logic [NUM_PORTS-1:0]  gnt_oh;
    logic                  xfer;

    // A stalled grant is pinned via lock_id so later arrivals cannot preempt it.
    always_comb begin
        logic        found;
        int unsigned idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (lock_vld) begin
            grant = lock_id;
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                idx = RR_EN ? ((32'(rr_ptr) + i) % NUM_PORTS) : i;
                if (!found && full[idx]) begin
                    grant = ID_W'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    assign o_valid = |full;
    assign o_busy  = |full;
    assign xfer    = o_valid & i_ready;
    assign o_id    = o_valid ? grant : '0;
    assign o_data  = o_valid ? data_q[grant] : '0;

    always_comb begin
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            gnt_oh[k]  = o_valid && (grant == ID_W'(k));
            o_ready[k] = ~full[k] | (gnt_oh[k] & i_ready);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full     <= '0;
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_id  <= '0;
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            // A refill accepted in the same cycle as its own transfer keeps the stage full.
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                if (i_valid[k] && o_ready[k]) begin
                    full[k]   <= 1'b1;
                    data_q[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
                end else if (xfer && gnt_oh[k]) begin
                    full[k] <= 1'b0;
                end
            end
            if (xfer) begin
                lock_vld <= 1'b0;
                if (RR_EN) begin
                    rr_ptr <= (grant == ID_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
                end
            end else if (o_valid) begin
                lock_vld <= 1'b1;
                lock_id  <= grant;
            end
        end
    end

endmodule

// File: tb/tb_arb_merge_rr_mmu.sv
// Bench for arb_merge_rr_mmu: round-robin and fixed-priority instances share stimulus
// and are compared every cycle against a behavioural model, plus directed literal checks.
module tb_arb_merge_rr_mmu;

    localparam int NP = 8;
    localparam int DW = 79;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic [NP-1:0] iv   = '0;
    logic          ir   = 1'b0;
    logic [DW-1:0] pd [NP];
    logic [NP*DW-1:0] idata;

    logic          ov   [2];
    logic          busy [2];
    logic [NP-1:0] ordy [2];
    logic [DW-1:0] od   [2];
    logic [2:0]    oid  [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NP; k++) idata[k*DW +: DW] = pd[k];
    end

    arb_merge_rr_mmu #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .RR_EN(1'b1)) u_rr (
        .clk(clk), .rstn(rstn), .i_valid(iv), .i_data(idata), .o_ready(ordy[0]),
        .o_valid(ov[0]), .o_data(od[0]), .o_id(oid[0]), .i_ready(ir), .o_busy(busy[0])
    );

    arb_merge_rr_mmu #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .RR_EN(1'b0)) u_fp (
        .clk(clk), .rstn(rstn), .i_valid(iv), .i_data(idata), .o_ready(ordy[1]),
        .o_valid(ov[1]), .o_data(od[1]), .o_id(oid[1]), .i_ready(ir), .o_busy(busy[1])
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    endtask

    // Model: mode 0 = round-robin, mode 1 = fixed priority.
    bit          m_full   [2][NP];
    bit [DW-1:0] m_data   [2][NP];
    int          m_ptr    [2];
    bit          m_lockv  [2];
    int          m_lockid [2];

    function automatic bit exp_any(input int m);
        for (int k = 0; k < NP; k++) if (m_full[m][k]) return 1'b1;
        return 1'b0;
    endfunction

    // Winner is the full port closest to the priority origin (distance modulo NP in RR mode).
    function automatic int exp_grant(input int m);
        int best, bestd, d;
        if (m_lockv[m]) return m_lockid[m];
        best  = 0;
        bestd = NP;
        for (int k = 0; k < NP; k++) begin
            if (m_full[m][k]) begin
                d = (m == 0) ? (k - m_ptr[m] + NP) % NP : k;
                if (d < bestd) begin
                    bestd = d;
                    best  = k;
                end
            end
        end
        return best;
    endfunction

    always @(posedge clk or negedge rstn) begin : model
        int g;
        bit v, x;
        bit rdy [NP];
        if (!rstn) begin
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < NP; k++) begin
                    m_full[m][k] = 1'b0;
                    m_data[m][k] = '0;
                end
                m_ptr[m]    = 0;
                m_lockv[m]  = 1'b0;
                m_lockid[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                g = exp_grant(m);
                v = exp_any(m);
                x = v && ir;
                for (int k = 0; k < NP; k++) rdy[k] = !m_full[m][k] || (x && k == g);
                if (x) begin
                    m_full[m][g] = 1'b0;
                    m_lockv[m]   = 1'b0;
                    if (m == 0) m_ptr[m] = (g + 1) % NP;
                end else if (v) begin
                    m_lockv[m]  = 1'b1;
                    m_lockid[m] = g;
                end
                for (int k = 0; k < NP; k++) begin
                    if (iv[k] && rdy[k]) begin
                        m_full[m][k] = 1'b1;
                        m_data[m][k] = pd[k];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int g;
        bit v;
        logic [NP-1:0] er;
        string tag;
        for (int m = 0; m < 2; m++) begin
            tag = (m == 0) ? "rr" : "fp";
            g = exp_grant(m);
            v = exp_any(m);
            for (int k = 0; k < NP; k++) er[k] = !m_full[m][k] || (v && ir && k == g);
            check({tag, "_valid"}, 128'(ov[m]), 128'(v));
            check({tag, "_busy"},  128'(busy[m]), 128'(v));
            check({tag, "_ready"}, 128'(ordy[m]), 128'(er));
            check({tag, "_id"},    128'(oid[m]), v ? 128'(g) : 128'(0));
            check({tag, "_data"},  128'(od[m]), v ? 128'(m_data[m][g]) : 128'(0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        iv   = '0;
        ir   = 1'b0;
        tick();
        @(negedge clk);
        check("rst_ready_rr", 128'(ordy[0]), 128'hFF);
        check("rst_valid_rr", 128'(ov[0]), 128'h0);
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NP; k++) pd[k] = '0;

        // Single word on port 3
        do_reset();
        pd[3] = 79'h1234;
        iv    = 8'h08;
        @(negedge clk);
        check("t1_not_yet", 128'(ov[0]), 128'h0);
        tick();
        iv = '0;
        @(negedge clk);
        check("t1_valid", 128'(ov[0]), 128'h1);
        check("t1_id",    128'(oid[0]), 128'h3);
        check("t1_data",  128'(od[0]), 128'h1234);
        check("t1_id_fp", 128'(oid[1]), 128'h3);
        tick();
        ir = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("t1_empty", 128'(ov[0]), 128'h0);

        // Round-robin saturation
        do_reset();
        ir = 1'b1;
        iv = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < NP; k++) pd[k] = DW'(c * 16 + k);
            @(negedge clk);
            if (c >= 1) begin
                check("t2_rr_id",    128'(oid[0]), 128'((c - 1) % NP));
                check("t2_rr_valid", 128'(ov[0]), 128'h1);
                check("t2_fp_id",    128'(oid[1]), 128'h0);
            end
            tick();
        end
        iv = '0;
        repeat (10) tick();

        // Fixed priority, ports 2 and 5
        do_reset();
        ir = 1'b1;
        iv = 8'h24;
        pd[5] = 79'd200;
        for (int c = 0; c < 6; c++) begin
            pd[2] = DW'(100 + c);
            @(negedge clk);
            if (c >= 1) begin
                check("t3_fp_id",   128'(oid[1]), 128'h2);
                check("t3_fp_rdy5", 128'(ordy[1][5]), 128'h0);
            end
            tick();
        end
        iv = 8'h20;
        @(negedge clk);
        check("t3_fp_last2", 128'(oid[1]), 128'h2);
        tick();
        @(negedge clk);
        check("t3_fp_id5",   128'(oid[1]), 128'h5);
        check("t3_fp_data5", 128'(od[1]), 128'd200);
        tick();
        iv = '0;
        repeat (6) tick();

        // Stall lock on port 4 while port 0 arrives
        do_reset();
        ir    = 1'b0;
        pd[4] = 79'hA4A4;
        iv    = 8'h10;
        @(negedge clk);
        tick();
        iv    = 8'h01;
        pd[0] = 79'hB0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("t4_rr_id",   128'(oid[0]), 128'h4);
            check("t4_rr_data", 128'(od[0]), 128'hA4A4);
            check("t4_fp_id",   128'(oid[1]), 128'h4);
            tick();
            iv = '0;
        end
        ir = 1'b1;
        @(negedge clk);
        check("t4_xfer_id", 128'(oid[0]), 128'h4);
        tick();
        @(negedge clk);
        check("t4_next_id",   128'(oid[0]), 128'h0);
        check("t4_next_data", 128'(od[0]), 128'hB0);
        check("t4_fp_next",   128'(oid[1]), 128'h0);
        tick();

        // Wrap from pointer 7 with refill
        do_reset();
        ir    = 1'b1;
        pd[6] = 79'h66;
        iv    = 8'h40;
        @(negedge clk);
        tick();
        iv    = 8'h82;
        pd[7] = 79'h77A;
        pd[1] = 79'h11;
        @(negedge clk);
        check("t5_id6", 128'(oid[0]), 128'h6);
        tick();
        iv    = 8'h80;
        pd[7] = 79'h77B;
        @(negedge clk);
        check("t5_id7",   128'(oid[0]), 128'h7);
        check("t5_data7", 128'(od[0]), 128'h77A);
        check("t5_rdy7",  128'(ordy[0][7]), 128'h1);
        tick();
        iv = '0;
        @(negedge clk);
        check("t5_id1", 128'(oid[0]), 128'h1);
        tick();
        @(negedge clk);
        check("t5_id7b",   128'(oid[0]), 128'h7);
        check("t5_data7b", 128'(od[0]), 128'h77B);
        tick();
        @(negedge clk);
        check("t5_empty", 128'(ov[0]), 128'h0);
        repeat (3) tick();

        // Async reset mid-stream
        do_reset();
        ir    = 1'b1;
        pd[4] = 79'h44;
        iv    = 8'h10;
        @(negedge clk);
        tick();
        iv = '0;
        @(negedge clk);
        tick();
        ir    = 1'b0;
        iv    = 8'hA4;
        pd[2] = 79'h22;
        pd[5] = 79'h55;
        pd[7] = 79'h77;
        @(negedge clk);
        tick();
        iv = '0;
        @(negedge clk);
        check("t6_pre_valid", 128'(ov[0]), 128'h1);
        check("t6_pre_busy",  128'(busy[0]), 128'h1);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_valid", 128'(ov[0]), 128'h0);
        check("t6_rst_busy",  128'(busy[0]), 128'h0);
        check("t6_rst_ready", 128'(ordy[0]), 128'hFF);
        check("t6_rst_fp",    128'(ov[1]), 128'h0);
        tick();
        rstn  = 1'b1;
        ir    = 1'b1;
        iv    = 8'h42;
        pd[1] = 79'h101;
        pd[6] = 79'h606;
        @(negedge clk);
        tick();
        iv = '0;
        @(negedge clk);
        check("t6_first_id",   128'(oid[0]), 128'h1);
        check("t6_first_data", 128'(od[0]), 128'h101);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
